// File: rtl/flash_boot_loader.sv
`default_nettype none
// ============================================================================
// flash_boot_loader: copies WORD_COUNT flash words into instruction RAM, then
// releases the CPU. Optional trailing-sum check: BOOT_CHECKSUM_EN.   Rev 1.0
// ============================================================================
module flash_boot_loader #(
  parameter int unsigned WORD_COUNT     = 1024,
  parameter int unsigned RAM_ADDR_W     = 10,
  parameter logic [23:0] FLASH_BASE     = 24'h000000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  flash_enable,
  output logic                  read_enable,
  output logic                  write_enable,
  output logic [23:0]           readAddress,
  input  logic                  flash_ready,
  input  logic [31:0]           flash_data,
  output logic                  ram_we,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic                  cpu_reset_n,
  output logic                  boot_done,
  output logic                  boot_error
);
  localparam int unsigned IDX_W = RAM_ADDR_W + 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] WC_IDX   = IDX_W'(WORD_COUNT);
`ifdef BOOT_CHECKSUM_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT);
`else
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);
`endif
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_REQ       = 3'd0,
    S_WAIT_ACK  = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_WRITE     = 3'd3,
    S_FINISH    = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  state_t                r_state, w_state;
  logic [IDX_W-1:0]      r_idx, w_idx;
  logic [CNT_W-1:0]      r_cnt, w_cnt;
  logic                  w_flash_enable, w_read_enable, w_ram_we;
  logic                  w_cpu_reset_n, w_boot_done, w_boot_error;
  logic [23:0]           w_read_address;
  logic [RAM_ADDR_W-1:0] w_ram_addr;
  logic [31:0]           w_ram_wdata;
  logic                  w_timeout, w_go_fin, w_go_err;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]           r_sum, w_sum, r_data, w_data;
`endif

  always_comb begin
    w_state        = r_state;
    w_idx          = r_idx;
    w_cnt          = r_cnt;
    w_flash_enable = flash_enable;
    w_read_enable  = read_enable;
    w_read_address = readAddress;
    w_ram_we       = 1'b0;
    w_ram_addr     = ram_addr;
    w_ram_wdata    = ram_wdata;
    w_cpu_reset_n  = cpu_reset_n;
    w_boot_done    = boot_done;
    w_boot_error   = boot_error;
`ifdef BOOT_CHECKSUM_EN
    w_sum          = r_sum;
    w_data         = r_data;
`endif
    w_go_fin       = 1'b0;
    w_go_err       = 1'b0;
    // >= guards against the counter running past the limit after a late ack
    w_timeout      = (r_cnt >= CNT_LAST);

    unique case (r_state)
      S_REQ: begin
        w_flash_enable = 1'b1;
        w_read_enable  = 1'b1;
        w_read_address = FLASH_BASE + (24'(r_idx) << 2);
        w_cnt          = '0;
        w_state        = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        w_cnt = r_cnt + 1'b1;
        if (!flash_ready) begin
          w_read_enable = 1'b0;
          w_state       = S_WAIT_DATA;
        end else if (w_timeout) begin
          w_go_err = 1'b1;
        end
      end
      S_WAIT_DATA: begin
        w_cnt = r_cnt + 1'b1;
        if (flash_ready) begin
          w_state = S_WRITE;
          if (r_idx != WC_IDX) begin
            w_ram_we    = 1'b1;
            w_ram_addr  = r_idx[RAM_ADDR_W-1:0];
            w_ram_wdata = flash_data;
`ifdef BOOT_CHECKSUM_EN
            w_sum       = r_sum + flash_data;
`endif
          end
`ifdef BOOT_CHECKSUM_EN
          w_data = flash_data;
`endif
        end else if (w_timeout) begin
          w_go_err = 1'b1;
        end
      end
      S_WRITE: begin
        if (r_idx == LAST_IDX) begin
`ifdef BOOT_CHECKSUM_EN
          if (r_data == r_sum) w_go_fin = 1'b1;
          else                 w_go_err = 1'b1;
`else
          w_go_fin = 1'b1;
`endif
        end else begin
          w_idx   = r_idx + 1'b1;
          w_state = S_REQ;
        end
      end
      S_FINISH, S_ERROR: begin
        if (start) begin
          w_boot_done   = 1'b0;
          w_boot_error  = 1'b0;
          w_cpu_reset_n = 1'b0;
          w_idx         = '0;
`ifdef BOOT_CHECKSUM_EN
          w_sum         = '0;
`endif
          w_state       = S_REQ;
        end
      end
      default: w_state = S_REQ;
    endcase

    if (w_go_fin) begin
      w_flash_enable = 1'b0;
      w_read_enable  = 1'b0;
      w_boot_done    = 1'b1;
      w_cpu_reset_n  = 1'b1;
      w_state        = S_FINISH;
    end
    if (w_go_err) begin
      w_flash_enable = 1'b0;
      w_read_enable  = 1'b0;
      w_boot_error   = 1'b1;
      w_cpu_reset_n  = 1'b0;
      w_state        = S_ERROR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_REQ;
      r_idx        <= '0;
      r_cnt        <= '0;
      flash_enable <= 1'b0;
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      readAddress  <= '0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      cpu_reset_n  <= 1'b0;
      boot_done    <= 1'b0;
      boot_error   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      r_sum        <= '0;
      r_data       <= '0;
`endif
    end else begin
      r_state      <= w_state;
      r_idx        <= w_idx;
      r_cnt        <= w_cnt;
      flash_enable <= w_flash_enable;
      read_enable  <= w_read_enable;
      write_enable <= 1'b0;
      readAddress  <= w_read_address;
      ram_we       <= w_ram_we;
      ram_addr     <= w_ram_addr;
      ram_wdata    <= w_ram_wdata;
      cpu_reset_n  <= w_cpu_reset_n;
      boot_done    <= w_boot_done;
      boot_error   <= w_boot_error;
`ifdef BOOT_CHECKSUM_EN
      r_sum        <= w_sum;
      r_data       <= w_data;
`endif
    end
  end
endmodule
`default_nettype wire

// File: doc/flash_boot_loader.md
# flash_boot_loader

Copies a fixed-size program image from SPI flash into instruction RAM after reset, then releases the CPU from reset. It sits directly upstream of the flash navigator: it drives the navigator's read request lines and consumes its 32-bit `data_out` words. It also drives the RAM write port and holds the core in reset until the image is loaded. It never writes to flash.

## Interface
Parameters:
- `WORD_COUNT`, 1024: number of 32-bit words copied; must be ≥1.
- `RAM_ADDR_W`, 10: RAM word-address width; requires 2^RAM_ADDR_W ≥ WORD_COUNT.
- `FLASH_BASE`, 24'h000000: byte address of word 0. The navigator adds its own fixed offset internally.
- `TIMEOUT_CYCLES`, 4096: maximum cycles allowed per word before the block reports an error.

Ports:
- `clk` input 1: single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle pulse that restarts a copy. Ignored while busy.
- `flash_enable` output 1: to navigator.
- `read_enable` output 1: to navigator.
- `write_enable` output 1: to navigator. Constant 0.
- `readAddress` output 24: byte address to navigator.
- `flash_ready` input 1: navigator `ready`.
- `flash_data` input 32: navigator `data_out`. Flash byte 0 arrives in bits [7:0].
- `ram_we` output 1: one-cycle RAM write strobe.
- `ram_addr` output RAM_ADDR_W: RAM word address.
- `ram_wdata` output 32: RAM write data.
- `cpu_reset_n` output 1: low holds the CPU in reset.
- `boot_done` output 1: the image is loaded.
- `boot_error` output 1: the load failed. Sticky until the next reset or `start`.

## Operation
- All outputs are registered.
- Reset values:
  - 0: `flash_enable`, `read_enable`, `write_enable`, `readAddress`, `ram_we`, `ram_addr`, `ram_wdata`, `cpu_reset_n`, `boot_done`, `boot_error`.
  - Word index `idx` = 0; state = REQ.
- States:
  - **REQ**: drive `flash_enable`=1, `read_enable`=1, `readAddress`=FLASH_BASE+4·idx (mod 2^24). Go to WAIT_ACK.
  - **WAIT_ACK**: hold the request until `flash_ready`=0. Then set `read_enable`=0 and go to WAIT_DATA.
  - **WAIT_DATA**: keep `flash_enable`=1. When `flash_ready`=1, capture `flash_data` and go to WRITE.
  - **WRITE**:
    - If idx<WORD_COUNT: `ram_we`=1 for exactly one cycle, `ram_addr`=idx, `ram_wdata`=captured word. Then either go to FINISH (idx==WORD_COUNT-1, or when the checksum index is next) or increment idx and go to REQ.
    - The checksum word (idx==WORD_COUNT) is never written to RAM; see Configuration.
  - **FINISH**: `flash_enable`=0, `boot_done`=1, `cpu_reset_n`=1. The block then idles.
  - **ERROR**: `flash_enable`=0, `read_enable`=0, `boot_error`=1. `cpu_reset_n` stays 0.
- Timeout: the per-word cycle counter clears on entry to REQ. If it reaches TIMEOUT_CYCLES in WAIT_ACK or WAIT_DATA, go to ERROR.
- `start` in FINISH or ERROR:
  - clears `boot_done`, `boot_error` and idx;
  - drives `cpu_reset_n`=0;
  - goes to REQ.
- `start` in any other state has no effect.
- `read_enable` must be low before the navigator returns to idle, so a read is never issued twice. `read_enable` and `flash_ready` are never both high after the acknowledge.
- Asserting `rst_n` mid-transfer aborts immediately and forces all outputs to their reset values. The RAM may hold a partial image. The copy restarts from word 0.

## Timing
- First request: `read_enable` rises on the first clock edge after `rst_n` deasserts.
- Per-word latency: navigator read time + 4 cycles (REQ, ack-detect, data-detect, WRITE).
- `ram_we` rises in the cycle after `flash_ready` is seen high.
- `cpu_reset_n` and `boot_done` rise together, one cycle after the last RAM write.
- `ram_addr` increments by 1 per word with no gaps. It never exceeds WORD_COUNT-1.

## Configuration
- Macro: `BOOT_CHECKSUM_EN`.
- Defined:
  - After word WORD_COUNT-1, one extra word is read at FLASH_BASE+4·WORD_COUNT. It is not written to RAM.
  - The block keeps a running 32-bit sum (mod 2^32) of all copied words.
  - Match: go to FINISH. Mismatch: go to ERROR with `cpu_reset_n` held low.
- Undefined: no extra read and no adder. `boot_error` reports timeouts only.

## Test plan
- **Basic copy**: WORD_COUNT=4; flash words 0x11111111, 0x22222222, 0x33333333, 0x44444444 → four single-cycle `ram_we` pulses at `ram_addr` 0..3 with those data; then `boot_done`=1 and `cpu_reset_n`=1; `readAddress` sequence 0, 4, 8, 12.
- **Checksum** (macro defined): checksum word 0xAAAAAAAA → `boot_done`=1. Checksum word 0xAAAAAAAB → `boot_error`=1, `cpu_reset_n`=0, exactly 4 RAM writes, 5 flash reads.
- **Timeout**: navigator holds `flash_ready`=1 and never acknowledges; TIMEOUT_CYCLES=16 → `boot_error`=1 within 17 cycles of the request; `read_enable`=0 afterwards.
- **Reset mid-copy**: assert `rst_n` low during word 2's WAIT_DATA → all outputs 0 immediately; after release the copy restarts at `readAddress`=FLASH_BASE.
- **Restart**: `start` pulse in FINISH → `cpu_reset_n` falls next cycle and a full recopy happens. `start` pulse during WAIT_DATA is ignored; no extra RAM writes.
- **Handshake check**: assertion that `read_enable` is never 1 while the navigator is in the ready-high phase that follows an acknowledged request.
